muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Sequential 16-bit multiply/divide unit in the execute stage, directly upstream of the register file.
//  MUL: low product goes to the normal write-back port (write_data/write_reg); high product goes to R0.
//  DIV: quotient goes to the normal write-back port; remainder goes to R0.
//  Drives the register file's reg_write/write_r0 strobes for one cycle when the operation completes.
// PARAMETERS
//  WIDTH     16  operand/result width; iteration count = WIDTH
//  REG_AW    5   register address width (matches register file read/write ports)
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  start      in   1        launch operation; sampled only in IDLE
//  op         in   1        0 = MUL, 1 = DIV
//  op_a       in   WIDTH    multiplicand / dividend
//  op_b       in   WIDTH    multiplier / divisor
//  dest_in    in   REG_AW   destination register of the low/quotient result
//  busy       out  1        high from the cycle after start until done inclusive
//  done       out  1        one-cycle completion pulse
//  result_lo  out  WIDTH    product[WIDTH-1:0] or quotient -> register file write_data
//  result_hi  out  WIDTH    product[2W-1:W] or remainder -> register file R0
//  dest_out   out  REG_AW   latched dest_in -> register file write_reg
//  reg_write  out  1        equals done
//  write_r0   out  1        equals done
//  div_zero   out  1        sticky until next accepted start; set by DIV with op_b == 0
// BEHAVIOUR
//  - Reset (async, any state): FSM -> IDLE; all outputs and internal registers are cleared to 0.
//  - FSM states: IDLE -> (start & !op) MUL | (start & op & b!=0) DIV | (start & op & b==0) DONE.
//    MUL/DIV -> DONE after exactly WIDTH iteration cycles. DONE -> IDLE unconditionally.
//  - Accepting start latches op_a, op_b, op and dest_in, and clears div_zero.
//  - start while not IDLE is ignored; it is not queued.
//  - Latency: start accepted in cycle 0; done is high in cycle WIDTH+1 (17 with defaults).
//    Divide-by-zero: done is high in cycle 1.
//  - MUL: unsigned shift-add over a 2*WIDTH accumulator; one multiplier bit per cycle, LSB first.
//  - DIV: unsigned restoring division; one quotient bit per cycle, MSB first.
//    Remainder is WIDTH bits; the trial subtract is WIDTH+1 bits wide.
//  - Divide by zero: quotient = all ones, remainder = op_a, div_zero = 1.
//  - result_lo, result_hi and dest_out update only in the DONE cycle and hold until the next DONE.
//  - done, reg_write and write_r0 are registered, high for exactly one cycle, never back-to-back.
//  - busy is low in IDLE only; a new start may be accepted in the cycle after done.
//  - Reset asserted mid-operation aborts the operation: no done pulse, outputs are zeroed.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined:
//    - Operands are two's complement; magnitudes are taken at start and sign-fixed in DONE.
//    - Product sign = a^b. Quotient sign = a^b; remainder sign = sign of dividend.
//    - Divide by zero: same results as the unsigned path.
//    - The -32768 / -1 case: quotient = 0x8000, remainder = 0; no trap.
//  MULDIV_SIGNED_EN undefined: all operations are unsigned; no sign logic is instantiated.
// STRUCTURE
//  - Package muldiv_pkg:
//    - OP_MUL/OP_DIV encodings
//    - state enum {IDLE, MUL, DIV, DONE}
//    - default WIDTH/REG_AW constants
//  - Sub-module muldiv_step (combinational): one shift-add or restore-subtract iteration.
//    Inputs: acc, operand, mode. Output: next acc. Instantiated once.
//  - Top level holds the FSM, iteration counter ($clog2(WIDTH)+1 bits), operand/result registers,
//    and the optional sign fix-up.
// TESTING
//  - MUL 0x0003 * 0x0004, dest 5 -> done at cycle 17; result_lo = 0x000C, result_hi = 0x0000,
//    dest_out = 5; reg_write = write_r0 = 1 for one cycle.
//  - MUL 0xFFFF * 0xFFFF (unsigned) -> result_hi = 0xFFFE, result_lo = 0x0001.
//    With MULDIV_SIGNED_EN: 0xFFFE * 0x0003 -> result_hi = 0xFFFF, result_lo = 0xFFFA.
//  - DIV 0x0064 / 0x0007 -> result_lo = 0x000E, result_hi = 0x0002, div_zero = 0.
//  - DIV 0x7B18 / 0x0000 -> done at cycle 1; result_lo = 0xFFFF, result_hi = 0x7B18, div_zero = 1.
//    div_zero clears on the next start.
//  - start pulsed at cycle 5 of a MUL with different operands -> ignored;
//    the original result is delivered at cycle 17 and there is exactly one done.
//  - reset asserted at cycle 8 of a DIV -> outputs 0 immediately and busy = 0; no done pulse.
//    A new MUL started after reset completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings, FSM states and default sizes for the multiply/divide unit
package muldiv_pkg;
   localparam int DEF_WIDTH  = 16;
   localparam int DEF_REG_AW = 5;
   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add (MUL) or restoring subtract (DIV)
// Ports: acc = {high half, low half} working register; operand = multiplicand / divisor;
//   mode = OP_MUL or OP_DIV; next_acc = accumulator after this iteration.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  logic               mode,
   output logic [2*WIDTH-1:0] next_acc
);
   logic [WIDTH:0] sum, shifted, diff;
   // MUL: low half holds the multiplier, consumed LSB first; carry shifts into the high half
   assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
   // DIV: low half holds the dividend, shifted MSB first into the remainder; quotient bits fill in from the right
   assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign diff = shifted - {1'b0, operand};
   assign next_acc = mode == OP_DIV
      ? {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
      : {sum, acc[WIDTH-1:1]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential multiply/divide unit driving register file write-back and R0
// Ports: clk; reset (async, active-high); start/op/op_a/op_b/dest_in launch an operation from IDLE;
//   busy, done, div_zero status; result_lo -> write_data, dest_out -> write_reg, result_hi -> R0;
//   reg_write and write_r0 mirror done. Define MULDIV_SIGNED_EN for two's-complement operands.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   input  logic [REG_AW-1:0] dest_in,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result_lo,
   output logic [WIDTH-1:0]  result_hi,
   output logic [REG_AW-1:0] dest_out,
   output logic              reg_write,
   output logic              write_r0,
   output logic              div_zero
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] acc, next_acc, fin;
   logic [WIDTH-1:0] b_reg, a_mag, b_mag;
   logic [REG_AW-1:0] dest_q;
   logic op_reg, zero_div;
   assign zero_div = op == OP_DIV && op_b == '0;
   assign busy = state != IDLE;
   assign reg_write = done;
   assign write_r0 = done;
`ifdef MULDIV_SIGNED_EN
   logic neg_q, neg_r;
   // iterate on magnitudes; -2^(W-1) maps to itself, which is the correct unsigned magnitude
   assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
   assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;
   assign fin = op_reg == OP_MUL ? (neg_q ? -next_acc : next_acc)
      : {neg_r ? -next_acc[2*WIDTH-1:WIDTH] : next_acc[2*WIDTH-1:WIDTH],
         neg_q ? -next_acc[WIDTH-1:0] : next_acc[WIDTH-1:0]};
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == IDLE && start) begin
         neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
         neg_r <= op_a[WIDTH-1];
      end
`else
   assign a_mag = op_a;
   assign b_mag = op_b;
   assign fin = next_acc;
`endif
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc(acc),
      .operand(b_reg),
      .mode(op_reg),
      .next_acc(next_acc)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         acc <= '0;
         b_reg <= '0;
         op_reg <= OP_MUL;
         dest_q <= '0;
         dest_out <= '0;
         result_lo <= '0;
         result_hi <= '0;
         done <= 1'b0;
         div_zero <= 1'b0;
      end else
         case (state)
            IDLE:
               if (start) begin
                  op_reg <= op;
                  b_reg <= b_mag;
                  dest_q <= dest_in;
                  cnt <= '0;
                  acc <= {{WIDTH{1'b0}}, a_mag};
                  div_zero <= zero_div;
                  // divide by zero skips iteration and reports raw dividend as remainder
                  if (zero_div) begin
                     state <= DONE;
                     done <= 1'b1;
                     result_lo <= '1;
                     result_hi <= op_a;
                     dest_out <= dest_in;
                  end else
                     state <= op == OP_MUL ? MUL : DIV;
               end
            MUL, DIV: begin
               acc <= next_acc;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
                  done <= 1'b1;
                  result_lo <= fin[WIDTH-1:0];
                  result_hi <= fin[2*WIDTH-1:WIDTH];
                  dest_out <= dest_q;
               end
            end
            DONE: begin
               state <= IDLE;
               done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule
